// File: rtl/saadi_pkg.sv
// saadi_pkg
// Shared definitions for the SAADI-EC accumulation sequencer:
//   - default datapath / counter widths
//   - sequencer state encoding
//   - ec_form(): error-correction form of a final sum
package saadi_pkg;

    localparam int N  = 8;
    localparam int CW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CORR = 2'd2
    } state_t;

    // Force the MSB and keep the upper N-1 bits of the sum, shifted down one place.
    function automatic logic [N-1:0] ec_form(input logic [N-1:0] sum);
        return {1'b1, sum[N-1:1]};
    endfunction

endpackage

// File: rtl/saadi_acc_sequencer_sat_add.sv
// saadi_sat_add
// Combinational N-bit saturating adder.
// Ports:
//   a, b   in   N   addends
//   sum    out  N   a + b, or all-ones when the addition carries out
//   carry  out  1   carry-out of the raw N-bit addition
module saadi_sat_add #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         carry
);

    logic [N:0] raw;

    assign raw   = {1'b0, a} + {1'b0, b};
    assign carry = raw[N];
    assign sum   = raw[N] ? {N{1'b1}} : raw[N-1:0];

endmodule

// File: rtl/saadi_acc_sequencer.sv
// saadi_acc_sequencer
// Drives the SAADI-EC accumulation loop: latches an operand and shift mask on
// start, adds (dividend >> k) into a saturating sum for each set mask bit k over
// T = min(t, N) iterations, then returns the (optionally error-corrected) sum.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     operand, latched on accepted start
//   shift_mask   bit k selects term (dividend >> k) at iteration k
//   t            requested iteration count (clamped to N)
//   ec_en        apply ec_form() to the result
//   busy         high from the cycle after accepted start until done
//   counter      current iteration index, holds T after completion
//   done         one-cycle pulse, quotient valid
//   quotient     result, held until the next result is produced
//   ovf          sticky saturation flag of the current operation
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one iteration per cycle, k = counter
// CORR  | form quotient, pulse done, return to IDLE
import saadi_pkg::*;

module saadi_acc_sequencer #(
    parameter int N  = saadi_pkg::N,
    parameter int CW = saadi_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  dividend,
    input  logic [N-1:0]  shift_mask,
    input  logic [CW-1:0] t,
    input  logic          ec_en,
    output logic          busy,
    output logic [CW-1:0] counter,
    output logic          done,
    output logic [N-1:0]  quotient,
    output logic          ovf
);

    localparam int KW = $clog2(N);

    state_t        state, state_nxt;
    logic [N-1:0]  dividend_q, dividend_nxt;
    logic [N-1:0]  mask_q, mask_nxt;
    logic [N-1:0]  sum_q, sum_nxt;
    logic [CW-1:0] t_q, t_nxt;
    logic          ec_q, ec_nxt;
    logic          busy_nxt, done_nxt, ovf_nxt;
    logic [CW-1:0] counter_nxt;
    logic [N-1:0]  quotient_nxt;

    logic [CW-1:0] t_eff;
    logic [N-1:0]  term;
    logic [N-1:0]  add_sum;
    logic          add_carry;

    assign t_eff = (t > CW'(N)) ? CW'(N) : t;
    // counter stays below N in RUN, so the shift never exceeds N-1.
    assign term  = dividend_q >> counter;

    saadi_sat_add #(.N(N)) u_sat_add (
        .a     (sum_q),
        .b     (term),
        .sum   (add_sum),
        .carry (add_carry)
    );

    always_comb begin
        state_nxt    = state;
        dividend_nxt = dividend_q;
        mask_nxt     = mask_q;
        sum_nxt      = sum_q;
        t_nxt        = t_q;
        ec_nxt       = ec_q;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        ovf_nxt      = ovf;
        counter_nxt  = counter;
        quotient_nxt = quotient;
        case (state)
            IDLE: begin
                if (start) begin
                    dividend_nxt = dividend;
                    mask_nxt     = shift_mask;
                    ec_nxt       = ec_en;
                    t_nxt        = t_eff;
                    sum_nxt      = '0;
                    counter_nxt  = '0;
                    ovf_nxt      = 1'b0;
                    busy_nxt     = 1'b1;
                    state_nxt    = (t_eff != '0) ? RUN : CORR;
                end
            end
            RUN: begin
                if (mask_q[counter[KW-1:0]]) begin
                    sum_nxt = add_sum;
                    if (add_carry) begin
                        ovf_nxt = 1'b1;
                    end
                end
                counter_nxt = counter + CW'(1);
                if (counter + CW'(1) == t_q) begin
                    state_nxt = CORR;
                end
            end
            CORR: begin
                quotient_nxt = ec_q ? ec_form(sum_q) : sum_q;
                done_nxt     = 1'b1;
                busy_nxt     = 1'b0;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dividend_q <= '0;
            mask_q     <= '0;
            sum_q      <= '0;
            t_q        <= '0;
            ec_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            counter    <= '0;
            quotient   <= '0;
        end else begin
            state      <= state_nxt;
            dividend_q <= dividend_nxt;
            mask_q     <= mask_nxt;
            sum_q      <= sum_nxt;
            t_q        <= t_nxt;
            ec_q       <= ec_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            ovf        <= ovf_nxt;
            counter    <= counter_nxt;
            quotient   <= quotient_nxt;
        end
    end

endmodule

// File: tb/tb_saadi_acc_sequencer.sv
// tb_saadi_acc_sequencer
// Directed bench for saadi_acc_sequencer: reset values, several accumulation
// cases with hand-computed quotients and latencies, t clamping, mid-run reset,
// start filtering while busy and back-to-back start in the done cycle.
module tb_saadi_acc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] shift_mask;
    logic [7:0] t;
    logic       ec_en;
    logic       busy;
    logic [7:0] counter;
    logic       done;
    logic [7:0] quotient;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    saadi_acc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .shift_mask (shift_mask),
        .t          (t),
        .ec_en      (ec_en),
        .busy       (busy),
        .counter    (counter),
        .done       (done),
        .quotient   (quotient),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after the start edge; returns number of edges taken.
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] dv, input logic [7:0] mk,
                          input logic [7:0] tt, input logic ec,
                          input logic [7:0] exp_q, input logic exp_ovf,
                          input int exp_lat, input logic [7:0] exp_cnt);
        int edges;
        dividend = dv; shift_mask = mk; t = tt; ec_en = ec; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(tag, edges);
        check({tag, "_lat"}, 32'(edges), 32'(exp_lat));
        check({tag, "_q"}, 32'(quotient), 32'(exp_q));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_cnt"}, 32'(counter), 32'(exp_cnt));
        tick();
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_qhold"}, 32'(quotient), 32'(exp_q));
    endtask

    initial begin
        int edges;
        rst = 1'b1; start = 1'b0; dividend = '0; shift_mask = '0; t = '0; ec_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cnt", 32'(counter), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        tick();

        //     tag      dv     mask   t      ec    q      ovf   lat cnt
        run_op("c0",   8'hC0, 8'h05, 8'd3,  1'b0, 8'hF0, 1'b0, 4,  8'd3);
        run_op("ec40", 8'h40, 8'h01, 8'd1,  1'b1, 8'hA0, 1'b0, 2,  8'd1);
        run_op("sat",  8'hFF, 8'hFF, 8'd8,  1'b0, 8'hFF, 1'b1, 9,  8'd8);
        run_op("t0",   8'hAA, 8'hFF, 8'd0,  1'b1, 8'h80, 1'b0, 1,  8'd0);
        run_op("clmp", 8'h80, 8'h80, 8'd20, 1'b0, 8'h01, 1'b0, 9,  8'd8);
        run_op("clmp2",8'hE4, 8'h80, 8'd20, 1'b0, 8'h01, 1'b0, 9,  8'd8);

        // Reset in the middle of a saturating run.
        dividend = 8'hFF; shift_mask = 8'hFF; t = 8'd8; ec_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("mid_ovf", 32'(ovf), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_cnt", 32'(counter), 32'd0);
        check("mr_q", 32'(quotient), 32'd0);
        check("mr_ovf", 32'(ovf), 32'd0);
        edges = 0;
        repeat (10) begin
            tick();
            if (done) edges++;
        end
        check("mr_nodone", 32'(edges), 32'd0);
        run_op("post", 8'hC0, 8'h05, 8'd3, 1'b0, 8'hF0, 1'b0, 4, 8'd3);

        // start held high: only first accepted, then re-accepted in the done cycle.
        dividend = 8'hC0; shift_mask = 8'h05; t = 8'd3; ec_en = 1'b0; start = 1'b1;
        tick();
        dividend = 8'h40; shift_mask = 8'h01; t = 8'd1; ec_en = 1'b1;
        wait_done("spam", edges);
        check("spam_lat", 32'(edges), 32'd4);
        check("spam_q", 32'(quotient), 32'hF0);
        check("spam_cnt", 32'(counter), 32'd3);
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_done", 32'(done), 32'd0);
        check("b2b_cnt", 32'(counter), 32'd0);
        wait_done("b2b", edges);
        check("b2b_lat", 32'(edges), 32'd2);
        check("b2b_q", 32'(quotient), 32'hA0);
        check("b2b_ovf", 32'(ovf), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
